// File: rtl/csd_mult_seq.sv
// Sequential multiplier: one CSD digit per cycle, signed add/sub/hold.
// Define CSD_MULT_SKIP_EN to stop once all remaining digits are zero.
module csd_mult_seq #(
  parameter  int DATA_W = 24,
  parameter  int CSD_N  = 14,
  localparam int OUT_W  = DATA_W + CSD_N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*CSD_N-1:0]      csd_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    err
);

  localparam int KW = (CSD_N > 1) ? $clog2(CSD_N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [2*CSD_N-1:0]       csd_q, csd_d;
  logic signed [OUT_W-1:0]  mcand_q, mcand_d;
  logic signed [OUT_W-1:0]  acc_q, acc_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [OUT_W-1:0]  dout_q, dout_d;
  logic                     err_q, err_d;

  logic [1:0]               digit;
  logic                     ill;
  logic                     last;
  logic signed [OUT_W-1:0]  addend;
  logic signed [OUT_W-1:0]  sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      csd_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      csd_q   <= csd_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    digit  = csd_q[{k_q, 1'b0} +: 2];
    addend = mcand_q <<< k_q;
    ill    = 1'b0;
    for (int i = 0; i < CSD_N; i++) begin
      if (csd_q[2*i +: 2] == 2'b11) ill = 1'b1;
    end
    last = (k_q == KW'(CSD_N - 1));
`ifdef CSD_MULT_SKIP_EN
    // Finish early once no nonzero digit remains above k.
    begin
      logic hi_nz;
      hi_nz = 1'b0;
      for (int i = 0; i < CSD_N; i++) begin
        if (i > int'(k_q) && csd_q[2*i +: 2] != 2'b00) hi_nz = 1'b1;
      end
      if (!hi_nz) last = 1'b1;
    end
`endif
    unique case (1'b1)
      (digit == 2'b01): sum = acc_q + addend;
      (digit == 2'b10): sum = acc_q - addend;
      default:          sum = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    csd_d   = csd_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    k_d     = k_q;
    dout_d  = dout_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          csd_d   = csd_in;
          mcand_d = {{CSD_N{data_in[DATA_W-1]}}, data_in};
          acc_d   = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ill) begin
          dout_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          acc_d = sum;
          if (last) begin
            dout_d  = sum;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    data_out  = dout_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_csd_mult_seq.sv
// Bench for csd_mult_seq: arithmetic reference model plus directed vectors.
// Honours CSD_MULT_SKIP_EN for the expected latency.
module tb_csd_mult_seq;

  localparam int DW = 24;
  localparam int CN = 14;
  localparam int OW = DW + CN;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [2*CN-1:0]       csd_in = '0;
  logic signed [DW-1:0]  data_in = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic signed [OW-1:0]  data_out;
  logic                  err;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  csd_mult_seq #(.DATA_W(DW), .CSD_N(CN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .csd_in(csd_in), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit has_ill(input logic [2*CN-1:0] c);
    for (int i = 0; i < CN; i++) if (c[2*i +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic longint prod(input longint d, input logic [2*CN-1:0] c);
    longint s = 0;
    if (has_ill(c)) return 0;
    for (int i = 0; i < CN; i++) begin
      if (c[2*i +: 2] == 2'b01) s += d * (longint'(1) << i);
      if (c[2*i +: 2] == 2'b10) s -= d * (longint'(1) << i);
    end
    return s;
  endfunction

  function automatic int lat(input logic [2*CN-1:0] c);
    int h = -1;
    if (has_ill(c)) return 1;
    for (int i = 0; i < CN; i++) if (c[2*i +: 2] != 2'b00) h = i;
`ifdef CSD_MULT_SKIP_EN
    return (h + 1 > 1) ? h + 1 : 1;
`else
    return CN;
`endif
  endfunction

  // Reference model: 0 idle, 1 run, 2 done
  int     ms = 0;
  int     mcnt = 0;
  int     mR = 0;
  longint mexp = 0;
  bit     merr = 1'b0;
  longint mlast = 0;

  always @(posedge clk) begin
    if (rst) begin
      ms = 0;
      mlast = 0;
    end else begin
      case (ms)
        0: if (in_valid) begin
          mexp = prod(longint'(data_in), csd_in);
          merr = has_ill(csd_in);
          mR   = lat(csd_in);
          mcnt = 0;
          ms   = 1;
        end
        1: begin
          mcnt++;
          if (mcnt == mR) begin
            ms = 2;
            mlast = mexp;
          end
        end
        default: if (out_ready) ms = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", longint'(in_ready), longint'(ms == 0));
      check("out_valid", longint'(out_valid), longint'(ms == 2));
      check("data_out", longint'(data_out), mlast);
      if (ms == 2) check("err", longint'(err), longint'(merr));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic do_op(input logic signed [DW-1:0] d, input logic [2*CN-1:0] c,
                       input int hold, output int l,
                       output longint dv, output bit ev);
    logic signed [OW-1:0] held;
    wait_idle();
    data_in = d;
    csd_in = c;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 0;
    while (!out_valid && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
    if (!out_valid) check("result_timeout", 0, 1);
    dv = longint'(data_out);
    ev = err;
    held = data_out;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      data_in = 24'sd7;
      csd_in = 28'h0000001;
      @(posedge clk); #1;
      check("hold_valid", longint'(out_valid), 1);
      check("hold_ready", longint'(in_ready), 0);
      check("hold_data", longint'(data_out), longint'(held));
    end
    if (hold > 0) begin
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_ready", longint'(in_ready), 1);
      check("release_valid", longint'(out_valid), 0);
    end
  endtask

  int     l;
  longint dv;
  bit     ev;
  int     lat_short;
  int     lat_four;

  initial begin
`ifdef CSD_MULT_SKIP_EN
    lat_short = 1;
    lat_four  = 4;
`else
    lat_short = CN;
    lat_four  = CN;
`endif
    check("model_100", prod(100, 28'h0000001), 100);
    check("model_m35", prod(-5, 28'h0000042), -35);
    check("model_big", prod(-8388608, 28'h8000000), 64'sd68719476736);
    check("model_ill", longint'(has_ill(28'h0000003)), 1);

    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_ready", longint'(in_ready), 1);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_data", longint'(data_out), 0);

    do_op(24'sd100, 28'h0000001, 0, l, dv, ev);
    check("v100_data", dv, 100);
    check("v100_err", longint'(ev), 0);
    check("v100_lat", l, lat_short);

    do_op(-24'sd5, 28'h0000042, 0, l, dv, ev);
    check("vm35_data", dv, -35);
    check("vm35_err", longint'(ev), 0);
    check("vm35_lat", l, lat_four);

    do_op(-24'sd8388608, 28'h8000000, 0, l, dv, ev);
    check("vbig_data", dv, 64'sd68719476736);
    check("vbig_lat", l, CN);

    do_op(24'sd8388607, 28'h5555555, 0, l, dv, ev);
    check("vmax_data", dv, 64'sd137430548481);

    do_op(24'sd1234, 28'h0000000, 0, l, dv, ev);
    check("vzero_data", dv, 0);
    check("vzero_lat", l, lat_short);

    do_op(24'sd77, 28'h0000003, 0, l, dv, ev);
    check("vill_data", dv, 0);
    check("vill_err", longint'(ev), 1);
    check("vill_lat", l, 1);

    do_op(-24'sd5, 28'h0000042, 5, l, dv, ev);
    check("vhold_data", dv, -35);

    // Reset at k=5 of a full-length run
    wait_idle();
    data_in = 24'sd3;
    csd_in = 28'h4000001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", longint'(in_ready), 1);
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_data", longint'(data_out), 0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("mid_rst_no_out", longint'(out_valid), 0);

    do_op(24'sd3, 28'h4000001, 0, l, dv, ev);
    check("post_rst_data", dv, 24579);
    check("post_rst_lat", l, CN);

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
